// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-memory access sequencer: valid/ready request, load extension, stall and timeout.
// Optional build macro MISALIGN_CHK_EN traps misaligned h/w accesses without touching memory.
module mem_stage_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en_mem,
  input  logic        wr_en_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wdata_mem,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic        stall_pipe,
  output logic [31:0] rdata_mem,
  output logic        done_pulse,
  output logic        err_timeout,
  output logic        misalign_trap
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       funct3_r, funct3_s;
  logic [1:0]       lane_r, lane_s;
  logic             valid_s, we_s, done_s, err_s, trap_s, trap_hit_s;
  logic [31:0]      addr_s, wdata_s, rdata_s;
  logic [3:0]       be_s;

  function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: calc_be = 4'b0001 << a;
      3'b001, 3'b101: calc_be = 4'b0011 << {a[1], 1'b0};
      default:        calc_be = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000, 3'b100: calc_wdata = {4{wd[7:0]}};
      3'b001, 3'b101: calc_wdata = {2{wd[15:0]}};
      default:        calc_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h000000, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0000, h};
      default: load_extend = w;
    endcase
  endfunction

`ifdef MISALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = a[0];
      default:        is_misaligned = (a != 2'b00);
    endcase
  endfunction

  assign trap_hit_s = is_misaligned(funct3_mem, addr_mem[1:0]);
`else
  assign trap_hit_s = 1'b0;
`endif

  // Next-state, next-output and stall logic
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    valid_s    = req_valid;
    we_s       = req_we;
    addr_s     = req_addr;
    be_s       = req_be;
    wdata_s    = req_wdata;
    funct3_s   = funct3_r;
    lane_s     = lane_r;
    rdata_s    = rdata_mem;
    done_s     = 1'b0;
    err_s      = 1'b0;
    trap_s     = 1'b0;
    stall_pipe = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_en_mem || wr_en_mem) begin
          stall_pipe = 1'b1;
          if (trap_hit_s) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            trap_s  = 1'b1;
            rdata_s = 32'h0000_0000;
          end else begin
            state_s  = ST_REQ;
            cnt_s    = '0;
            valid_s  = 1'b1;
            we_s     = wr_en_mem;
            addr_s   = {addr_mem[31:2], 2'b00};
            be_s     = calc_be(funct3_mem, addr_mem[1:0]);
            wdata_s  = calc_wdata(funct3_mem, wdata_mem);
            funct3_s = funct3_mem;
            lane_s   = addr_mem[1:0];
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_pipe = 1'b1;
        cnt_s      = cnt_r + CNT_W'(1);
        // An accepted store has already reached memory, so it completes cleanly even at the limit.
        if (req_ready && req_we) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          valid_s = 1'b0;
          rdata_s = 32'h0000_0000;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          err_s   = 1'b1;
          valid_s = 1'b0;
          rdata_s = 32'h0000_0000;
        end else if (req_ready) begin
          state_s = ST_WAIT;
          valid_s = 1'b0;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        stall_pipe = 1'b1;
        cnt_s      = cnt_r + CNT_W'(1);
        if (resp_valid) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          rdata_s = load_extend(funct3_r, lane_r, resp_rdata);
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          err_s   = 1'b1;
          rdata_s = 32'h0000_0000;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      funct3_r      <= 3'b000;
      lane_r        <= 2'b00;
      req_valid     <= 1'b0;
      req_we        <= 1'b0;
      req_addr      <= 32'h0000_0000;
      req_be        <= 4'h0;
      req_wdata     <= 32'h0000_0000;
      rdata_mem     <= 32'h0000_0000;
      done_pulse    <= 1'b0;
      err_timeout   <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      funct3_r      <= funct3_s;
      lane_r        <= lane_s;
      req_valid     <= valid_s;
      req_we        <= we_s;
      req_addr      <= addr_s;
      req_be        <= be_s;
      req_wdata     <= wdata_s;
      rdata_mem     <= rdata_s;
      done_pulse    <= done_s;
      err_timeout   <= err_s;
      misalign_trap <= trap_s;
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl: directed and randomized accesses checked against a behavioural model.
// Follows MISALIGN_CHK_EN when the macro is defined for the build.
module tb_mem_stage_access_ctrl;
  localparam int TO = 16;
`ifdef MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en_mem, wr_en_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] addr_mem, wdata_mem;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall_pipe;
  logic [31:0] rdata_mem;
  logic        done_pulse, err_timeout, misalign_trap;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rd_en_mem(rd_en_mem), .wr_en_mem(wr_en_mem),
    .funct3_mem(funct3_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .stall_pipe(stall_pipe), .rdata_mem(rdata_mem), .done_pulse(done_pulse),
    .err_timeout(err_timeout), .misalign_trap(misalign_trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access width in bytes; undefined encodings behave as a word.
  function automatic int op_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    else if (f3 == 3'd1 || f3 == 3'd5) return 2;
    else return 4;
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int sz = op_size(f3);
    if (sz == 4) return 0;
    return (int'(a % 32'd4) / sz) * sz;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v = ((1 << op_size(f3)) - 1) << lane_off(f3, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = op_size(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    else return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int     sz = op_size(f3);
    longint v;
    v = (longint'(w) >> (8 * lane_off(f3, a))) & ((64'd1 << (8 * sz)) - 64'd1);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= longint'(64'd1 << (8 * sz - 1)))
      v = v - longint'(64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int sz = op_size(f3);
    return MIS_EN && (sz > 1) && ((a % sz) != 0);
  endfunction

  task automatic drive_idle();
    rd_en_mem  = 1'b0;
    wr_en_mem  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
  endtask

  // One complete access, entered and left just after a rising edge with the DUT idle.
  task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int rdy_dly, input int resp_dly,
                            input logic [31:0] rd);
    bit mis, in_wait, was_wait, fin, tmo;
    int k, wk;
    logic [31:0] exp_rd;
    mis = m_misaligned(f3, a);
    rd_en_mem = !st; wr_en_mem = st; funct3_mem = f3; addr_mem = a; wdata_mem = wd;
    req_ready = 1'b0; resp_valid = 1'($urandom % 2); resp_rdata = $urandom;
    @(negedge clk);
    chk("stall_detect", {31'd0, stall_pipe}, 32'd1);
    chk("reqv_detect", {31'd0, req_valid}, 32'd0);
    chk("done_detect", {31'd0, done_pulse}, 32'd0);
    @(posedge clk); #1;
    fin = mis; tmo = 1'b0; in_wait = 1'b0; k = 0; wk = 0; exp_rd = 32'd0;
    while (!fin) begin
      was_wait  = in_wait;
      req_ready = !was_wait && (k == rdy_dly);
      if (was_wait) resp_valid = (wk == resp_dly);
      else resp_valid = 1'($urandom % 2);
      resp_rdata = (was_wait && resp_valid) ? rd : $urandom;
      @(negedge clk);
      chk("stall_busy", {31'd0, stall_pipe}, 32'd1);
      chk("done_busy", {31'd0, done_pulse}, 32'd0);
      chk("reqv_busy", {31'd0, req_valid}, was_wait ? 32'd0 : 32'd1);
      if (!was_wait) begin
        chk("req_addr", req_addr, a & 32'hFFFF_FFFC);
        chk("req_be", {28'd0, req_be}, {28'd0, m_be(f3, a)});
        chk("req_wdata", req_wdata, m_wdata(f3, wd));
        chk("req_we", {31'd0, req_we}, {31'd0, st});
      end
      if (!was_wait && req_ready && st) fin = 1'b1;
      else if (was_wait && resp_valid) begin fin = 1'b1; exp_rd = m_load(f3, a, rd); end
      else if (k == TO - 1) begin fin = 1'b1; tmo = 1'b1; end
      else if (!was_wait && req_ready) in_wait = 1'b1;
      @(posedge clk); #1;
      k++;
      if (was_wait) wk++;
    end
    req_ready = 1'b0; resp_valid = 1'($urandom % 2); resp_rdata = $urandom;
    @(negedge clk);
    chk("done_pulse", {31'd0, done_pulse}, 32'd1);
    chk("stall_done", {31'd0, stall_pipe}, 32'd0);
    chk("reqv_done", {31'd0, req_valid}, 32'd0);
    chk("err_timeout", {31'd0, err_timeout}, {31'd0, tmo});
    chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, mis});
    if (!st || mis) chk("rdata_mem", rdata_mem, exp_rd);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("stall_idle", {31'd0, stall_pipe}, 32'd0);
    chk("done_idle", {31'd0, done_pulse}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; drive_idle();
    funct3_mem = 3'd0; addr_mem = 32'd0; wdata_mem = 32'd0; resp_rdata = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_req_we", {31'd0, req_we}, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_req_be", {28'd0, req_be}, 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    chk("rst_rdata", rdata_mem, 32'd0);
    chk("rst_done", {31'd0, done_pulse}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
    chk("rst_stall", {31'd0, stall_pipe}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_access(1'b1, 3'b010, 32'h0000_0100, 32'hCAFE_BABE, 0, 0, 32'd0);
    run_access(1'b0, 3'b000, 32'h0000_0203, 32'd0, 0, 2, 32'h8011_2233);
    run_access(1'b0, 3'b101, 32'h0000_0202, 32'd0, 1, 0, 32'hBEEF_0000);
    run_access(1'b0, 3'b010, 32'h0000_0300, 32'd0, 0, 99, 32'd0);
    run_access(1'b1, 3'b001, 32'h0000_0402, 32'h1234_5678, 99, 0, 32'd0);
    run_access(1'b0, 3'b001, 32'h0000_0502, 32'd0, 0, TO - 2, 32'h8001_7FFF);
    run_access(1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 1, 32'h0BAD_F00D);
    run_access(1'b1, 3'b001, 32'h0000_0103, 32'hA5A5_9696, 2, 0, 32'd0);
    run_access(1'b0, 3'b011, 32'h0000_0600, 32'd0, 0, 0, 32'hDEAD_BEEF);

    // Reset while waiting for the response; the late response must not complete anything.
    rd_en_mem = 1'b1; funct3_mem = 3'b000; addr_mem = 32'h0000_0040;
    @(posedge clk); #1;
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; rd_en_mem = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("rst_wait_stall", {31'd0, stall_pipe}, 32'd0);
    chk("rst_wait_done", {31'd0, done_pulse}, 32'd0);
    chk("rst_wait_reqv", {31'd0, req_valid}, 32'd0);
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    chk("rst_late_done", {31'd0, done_pulse}, 32'd0);
    chk("rst_late_stall", {31'd0, stall_pipe}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      bit          st;
      logic [2:0]  f3;
      st = 1'($urandom % 2);
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      run_access(st, f3, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 5), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
